// File: rtl/alu_pkg.sv
// Shared definitions for the registered execute-stage ALU: opcode map,
// controller states and the shift-amount width helper.
package alu_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b000011;
  localparam logic [5:0] OP_XOR  = 6'b000100;
  localparam logic [5:0] OP_SLTU = 6'b000101;
  localparam logic [5:0] OP_SLT  = 6'b000110;
  localparam logic [5:0] OP_SLL  = 6'b000111;
  localparam logic [5:0] OP_SRL  = 6'b001000;
  localparam logic [5:0] OP_SRA  = 6'b001001;
  localparam logic [5:0] OP_MUL  = 6'b001010;
  localparam logic [5:0] OP_DIVU = 6'b001011;
  localparam logic [5:0] OP_SW   = 6'b010000;
  localparam logic [5:0] OP_LW   = 6'b010001;
  localparam logic [5:0] OP_BEQ  = 6'b100000;
  localparam logic [5:0] OP_JMP  = 6'b100001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic int shamt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative shift-add multiplier / restoring unsigned divider, one bit per
// cycle, sharing one accumulator, two operand registers and a down-counter.
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = shamt_w(WIDTH) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;

  // Divide: acc is the partial remainder, opb shifts dividend bits out and
  // quotient bits in; a set sign bit in rem_diff means restore.
  assign rem_sh   = {acc_q, opb_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opa_q};

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    opa_d = opa_q;
    opb_d = opb_q;
    acc_d = acc_q;
    if (start_i) begin
      cnt_d = CNT_W'(WIDTH);
      div_d = div_i;
      opa_d = div_i ? b_i : a_i;
      opb_d = div_i ? a_i : b_i;
      acc_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (div_q) begin
        if (rem_diff[WIDTH]) begin
          acc_d = rem_sh[WIDTH-1:0];
          opb_d = {opb_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = rem_diff[WIDTH-1:0];
          opb_d = {opb_q[WIDTH-2:0], 1'b1};
        end
      end else begin
        if (opb_q[0]) begin
          acc_d = acc_q + opa_q;
        end
        opa_d = {opa_q[WIDTH-2:0], 1'b0};
        opb_d = {1'b0, opb_q[WIDTH-1:1]};
      end
    end
  end

  // Done flags the final step so the caller can register its outcome
  // on the same edge that completes it.
  assign done_o   = (cnt_q == CNT_W'(1));
  assign result_o = div_q ? opb_d : acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= 1'b0;
      opa_q <= '0;
      opb_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered execute-stage ALU with valid/ready handshake; single-cycle ops
// complete next cycle, MUL/DIVU stall in the iterative unit for WIDTH cycles.
//
// state  | meaning
// IDLE   | in_ready high, waiting for an operation
// MUL    | iterative multiply in progress
// DIV    | iterative unsigned divide in progress
// DONE   | result registers valid, waiting for out_ready
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] npc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_o,
  output logic [WIDTH-1:0] addr_o,
  output logic             ife,
  output logic             busy
);

  localparam int SHW = shamt_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_q, alu_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             ife_q, ife_d;

  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_alu;
  logic [WIDTH-1:0] sc_addr;
  logic             sc_ife;

  logic             unused_npc;

  assign unused_npc = ^npc;

  assign accept   = in_valid && (state_q == S_IDLE);
  assign is_mul   = (op == OP_W'(OP_MUL));
  assign is_div   = (op == OP_W'(OP_DIVU));
  assign md_start = accept && (is_mul || is_div);
  assign shamt    = b[SHW-1:0];

  iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_start),
    .div_i    (is_div),
    .a_i      (a),
    .b_i      (b),
    .done_o   (md_done),
    .result_o (md_result)
  );

  always_comb begin
    sc_alu  = '0;
    sc_addr = '0;
    sc_ife  = 1'b0;
    case (op)
      OP_W'(OP_ADD):  sc_alu = a + b;
      OP_W'(OP_SUB):  sc_alu = a - b;
      OP_W'(OP_AND):  sc_alu = a & b;
      OP_W'(OP_OR):   sc_alu = a | b;
      OP_W'(OP_XOR):  sc_alu = a ^ b;
      OP_W'(OP_SLTU): sc_alu = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_W'(OP_SLT):  sc_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_W'(OP_SLL):  sc_alu = a << shamt;
      OP_W'(OP_SRL):  sc_alu = a >> shamt;
      OP_W'(OP_SRA):  sc_alu = WIDTH'($signed(a) >>> shamt);
      OP_W'(OP_SW): begin
        sc_alu  = b;
        sc_addr = a + imm;
      end
      OP_W'(OP_LW):   sc_addr = a + imm;
      OP_W'(OP_BEQ): begin
        sc_addr = imm;
        sc_ife  = (a == '0);
      end
      OP_W'(OP_JMP):  sc_addr = imm;
      default: begin
        sc_alu  = '0;
        sc_addr = '0;
        sc_ife  = 1'b0;
      end
    endcase
  end

  // Output registers only load when a result is produced, so they hold the
  // previous result through later MUL/DIV iterations.
  always_comb begin
    state_d = state_q;
    alu_d   = alu_q;
    addr_d  = addr_q;
    ife_d   = ife_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d = S_MUL;
          end else if (is_div) begin
            state_d = S_DIV;
          end else begin
            state_d = S_DONE;
            alu_d   = sc_alu;
            addr_d  = sc_addr;
            ife_d   = sc_ife;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (md_done) begin
          state_d = S_DONE;
          alu_d   = md_result;
          addr_d  = '0;
          ife_d   = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      alu_q   <= '0;
      addr_q  <= '0;
      ife_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
      addr_q  <= addr_d;
      ife_q   <= ife_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign alu_o     = alu_q;
  assign addr_o    = addr_q;
  assign ife       = ife_q;

endmodule
